spi_fpga_slave: RTL and testbench
=================================

// Module: spi_fpga_slave
// PURPOSE
//  SPI slave (target) for the far end of the SPI_FPGA_MASTER link. Oversamples SCLK/CS/MOSI in the IN_CLOCK domain.
//  Each frame it shifts in a PACK_LENGTH-bit word on MOSI and shifts out a buffered word on MISO, MSB first.
//  Supports all four CPOL/CPHA modes and back-to-back frames under one CS assertion.
//  Constraint: f_SCLK <= f_IN_CLOCK/8. CS-low to first SCLK edge >= 4 IN_CLOCK cycles.
// PARAMETERS
//  PACK_LENGTH        8                      bits per frame
//  CPOL               1'b0                   SCLK idle level
//  CPHA               1'b0                   0: sample on leading edge; 1: sample on trailing edge
//  IDLE_PATTERN       {PACK_LENGTH{1'b1}}    word sent when TX holding register is empty
//  SYNC_STAGES        2                      synchronizer depth on SCLK/CS/MOSI (>=2)
//  PACK_LENGTH_LOG_2  $clog2(PACK_LENGTH)    bit-counter width (derived)
// PORTS
//  IN_CLOCK          in   1   system clock
//  IN_RESET_N        in   1   asynchronous, active-low reset
//  SCLK              in   1   SPI clock from master
//  CS                in   1   chip select, active low
//  MOSI              in   1   master-out data
//  MISO              out  1   slave-out data; 1'bZ while synced CS high
//  IN_DATA           in   PL  next TX word
//  IN_DATA_VALID     in   1   write IN_DATA into the holding register when OUT_DATA_READY
//  OUT_DATA_READY    out  1   holding register empty
//  OUT_RECEIVE_DATA  out  PL  last complete RX word, held until the next completes
//  OUT_ACTION_DONE   out  1   1-cycle pulse: OUT_RECEIVE_DATA updated
//  OUT_UNDERRUN      out  1   1-cycle pulse: IDLE_PATTERN loaded because the holding register was empty
//  OUT_FRAME_ERROR   out  1   1-cycle pulse: CS deasserted mid-frame
//  OUT_BUSY          out  1   synced CS low
// BEHAVIOUR
//  Reset values: MISO=Z, OUT_DATA_READY=1, OUT_RECEIVE_DATA=0, all pulses and OUT_BUSY=0.
//  Reset also clears the shift registers and bit counter and sets state=S_IDLE. Reset mid-frame aborts silently.
//  Input sync: SYNC_STAGES flops, plus one flop for edge detect.
//    Leading edge = synced SCLK leaving CPOL; trailing edge = returning to CPOL.
//    Sample edge = leading if CPHA=0, else trailing; shift edge = the other.
//  FSM:
//    S_IDLE:  CS falls -> S_SHIFT, bit_cnt=0. If CPHA=0, load tx_sr immediately.
//    S_SHIFT: each sample edge: rx_sr <= {rx_sr[PL-2:0], MOSI}; bit_cnt++.
//      On the sample edge with bit_cnt==PL-1: OUT_RECEIVE_DATA <= the completed word; OUT_ACTION_DONE pulses 1 cycle later; bit_cnt wraps to 0.
//      CPHA=0: shift edges shift tx_sr left; the trailing edge after the last sample loads the next word (back-to-back).
//      CPHA=1: leading edge with bit_cnt==0 loads tx_sr; other leading edges shift left.
//      CS rises with bit_cnt!=0 -> OUT_FRAME_ERROR pulse, no DONE, discard rx_sr -> S_IDLE.
//      CS rises with bit_cnt==0 -> S_IDLE, no error.
//  MISO = tx_sr[PL-1] while synced CS low.
//  Load: takes the holding register if full (READY goes 1 next cycle); otherwise IDLE_PATTERN plus an OUT_UNDERRUN pulse.
//    Write and load in the same cycle with holding empty: load uses IDLE_PATTERN; the write is captured into holding.
//  IN_DATA_VALID while OUT_DATA_READY=0 is ignored (no overwrite).
//  Latency: CS fall to MISO valid <= SYNC_STAGES+2 cycles; last sample edge to DONE = SYNC_STAGES+2 cycles.
// STRUCTURE
//  Package spi_fpga_pkg: FSM state encoding (S_IDLE, S_SHIFT) and the RISE_EDGE/FALLING_EDGE constants shared with the master.
//  Sub-module spi_fpga_sync: SYNC_STAGES-deep 1-bit synchronizer with async active-low reset, instantiated for SCLK, CS, MOSI.
//    Reset values: SCLK->CPOL, CS->1, MOSI->0.
// TESTING
//  Mode 0, master sends 8'hA5, holding=8'h3C -> OUT_RECEIVE_DATA=8'hA5, exactly one DONE pulse, master reads 8'h3C, MISO Z after CS high.
//  Repeat for modes 1/2/3 with 8'h81 out, 8'h7E preloaded -> 8'h81 received, 8'h7E on master side in every mode.
//  One CS assertion, 16 SCLKs, MOSI 8'h11,8'h22; holding 8'h55, then 8'hAA written on READY -> two DONE pulses, MISO 8'h55 then 8'hAA.
//  No IN_DATA_VALID before frame, master sends 8'h00 -> MISO sends 8'hFF, one UNDERRUN pulse, RX 8'h00.
//  CS raised after 5 bits -> one FRAME_ERROR pulse, no DONE, OUT_RECEIVE_DATA unchanged; next full frame 8'h5A received correctly.
//  IN_RESET_N low after 3 bits -> MISO Z, READY=1, RX=0 immediately; after release, full frame 8'hC3 received correctly.

Source files
------------

// File: rtl/spi_fpga_pkg.sv
// Definitions shared by both ends of the SPI_FPGA link: FSM state encoding
// and SCLK edge-polarity selectors.
package spi_fpga_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   localparam logic RISE_EDGE    = 1'b1;
   localparam logic FALLING_EDGE = 1'b0;

   // True when a synchronized line moved from prev to cur in the direction pol.
   function automatic logic edge_hit(input logic prev, input logic cur, input logic pol);
      return (pol == RISE_EDGE) ? (!prev && cur) : (prev && !cur);
   endfunction

endpackage

// File: rtl/spi_fpga_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset
// to a per-instance value.
module spi_fpga_sync
   import spi_fpga_pkg::*;
#(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_fpga_slave.sv
// SPI slave for the far end of the SPI_FPGA link: oversampled SCLK/CS/MOSI,
// PACK_LENGTH-bit words MSB first, all CPOL/CPHA modes, back-to-back words.
module spi_fpga_slave
   import spi_fpga_pkg::*;
#(
   parameter int unsigned            PACK_LENGTH       = 8,
   parameter logic                   CPOL              = 1'b0,
   parameter logic                   CPHA              = 1'b0,
   parameter logic [PACK_LENGTH-1:0] IDLE_PATTERN      = '1,
   parameter int unsigned            SYNC_STAGES       = 2,
   parameter int unsigned            PACK_LENGTH_LOG_2 = $clog2(PACK_LENGTH)
) (
   input  logic                   IN_CLOCK,
   input  logic                   IN_RESET_N,
   input  logic                   SCLK,
   input  logic                   CS,
   input  logic                   MOSI,
   output logic                   MISO,
   input  logic [PACK_LENGTH-1:0] IN_DATA,
   input  logic                   IN_DATA_VALID,
   output logic                   OUT_DATA_READY,
   output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
   output logic                   OUT_ACTION_DONE,
   output logic                   OUT_UNDERRUN,
   output logic                   OUT_FRAME_ERROR,
   output logic                   OUT_BUSY
);

   localparam logic LEAD_POL  = (CPOL == 1'b0) ? RISE_EDGE : FALLING_EDGE;
   localparam logic TRAIL_POL = (CPOL == 1'b0) ? FALLING_EDGE : RISE_EDGE;
   localparam logic [PACK_LENGTH_LOG_2-1:0] LAST_BIT = PACK_LENGTH_LOG_2'(PACK_LENGTH - 1);

   logic sclk_s;
   logic cs_s;
   logic mosi_s;

   spi_fpga_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
      .clk   (IN_CLOCK),
      .rst_n (IN_RESET_N),
      .d     (SCLK),
      .q     (sclk_s)
   );

   spi_fpga_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk   (IN_CLOCK),
      .rst_n (IN_RESET_N),
      .d     (CS),
      .q     (cs_s)
   );

   spi_fpga_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk   (IN_CLOCK),
      .rst_n (IN_RESET_N),
      .d     (MOSI),
      .q     (mosi_s)
   );

   state_e                         state_q, state_d;
   logic [PACK_LENGTH_LOG_2-1:0]   bit_cnt_q, bit_cnt_d;
   logic [PACK_LENGTH-1:0]         rx_sr_q, rx_sr_d;
   logic [PACK_LENGTH-1:0]         tx_sr_q, tx_sr_d;
   logic [PACK_LENGTH-1:0]         rx_data_q, rx_data_d;
   logic [PACK_LENGTH-1:0]         hold_q, hold_d;
   logic                           hold_full_q, hold_full_d;
   logic                           word_done_q, word_done_d;
   logic                           done_q, done_d;
   logic                           underrun_q, underrun_d;
   logic                           frame_err_q, frame_err_d;
   logic                           sclk_prev_q, sclk_prev_d;
   logic                           cs_prev_q, cs_prev_d;

   logic                           lead_edge;
   logic                           trail_edge;
   logic                           sample_edge;
   logic                           shift_edge;
   logic                           cs_fall;
   logic                           cs_rise;
   logic                           load;
   logic [PACK_LENGTH-1:0]         load_word;
   logic [PACK_LENGTH-1:0]         rx_next;

   always_comb begin
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      lead_edge   = edge_hit(sclk_prev_q, sclk_s, LEAD_POL);
      trail_edge  = edge_hit(sclk_prev_q, sclk_s, TRAIL_POL);
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;
      cs_fall     = edge_hit(cs_prev_q, cs_s, FALLING_EDGE);
      cs_rise     = edge_hit(cs_prev_q, cs_s, RISE_EDGE);
      rx_next     = {rx_sr_q[PACK_LENGTH-2:0], mosi_s};
      load_word   = hold_full_q ? hold_q : IDLE_PATTERN;
   end

   // A shift edge seen with bit_cnt==0 is the start of a word in both phases:
   // CPHA=1 leading edge before the first sample, or the CPHA=0 trailing edge
   // right after the last sample of the previous word.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      rx_data_d   = rx_data_q;
      word_done_d = 1'b0;
      frame_err_d = 1'b0;
      load        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d   = S_SHIFT;
               bit_cnt_d = '0;
               rx_sr_d   = '0;
               load      = !CPHA;
            end
         end
         S_SHIFT: begin
            if (cs_rise) begin
               state_d     = S_IDLE;
               bit_cnt_d   = '0;
               rx_sr_d     = '0;
               frame_err_d = (bit_cnt_q != '0);
            end else begin
               if (sample_edge) begin
                  rx_sr_d = rx_next;
                  if (bit_cnt_q == LAST_BIT) begin
                     rx_data_d   = rx_next;
                     word_done_d = 1'b1;
                     bit_cnt_d   = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + PACK_LENGTH_LOG_2'(1);
                  end
               end
               if (shift_edge) begin
                  if (bit_cnt_q == '0) begin
                     load = 1'b1;
                  end else begin
                     tx_sr_d = {tx_sr_q[PACK_LENGTH-2:0], 1'b0};
                  end
               end
            end
         end
      endcase

      if (load) begin
         tx_sr_d = load_word;
      end
   end

   // A write that lands in the same cycle as a load from an empty register
   // is still captured; the load itself falls back to IDLE_PATTERN.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = load && !hold_full_q;
      done_d      = word_done_q;
      if (load && hold_full_q) begin
         hold_full_d = 1'b0;
      end
      if (IN_DATA_VALID && !hold_full_q) begin
         hold_d      = IN_DATA;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
      if (!IN_RESET_N) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         rx_data_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         word_done_q <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
         sclk_prev_q <= CPOL;
         cs_prev_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         rx_data_q   <= rx_data_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         word_done_q <= word_done_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
      end
   end

   assign MISO             = cs_s ? 1'bz : tx_sr_q[PACK_LENGTH-1];
   assign OUT_DATA_READY   = !hold_full_q;
   assign OUT_RECEIVE_DATA = rx_data_q;
   assign OUT_ACTION_DONE  = done_q;
   assign OUT_UNDERRUN     = underrun_q;
   assign OUT_FRAME_ERROR  = frame_err_q;
   assign OUT_BUSY         = !cs_s;

endmodule

// File: tb/tb_spi_fpga_slave.sv
// Bench for spi_fpga_slave: one instance per SPI mode, driven by a bit-level
// master and checked against a word-level holding/underrun/receive model.
`timescale 1ns/1ps
module tb_spi_fpga_slave;

   localparam int HALF = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst_n    = '1;
   logic [3:0] sclk     = 4'b1100;
   logic [3:0] cs       = '1;
   logic [3:0] mosi     = '0;
   logic [3:0] in_valid = '0;
   logic [7:0] in_data [4] = '{default: 8'h00};

   wire  [3:0] miso;
   wire  [3:0] ready;
   wire  [3:0] done;
   wire  [3:0] underrun;
   wire  [3:0] ferr;
   wire  [3:0] busy;
   wire  [7:0] rxd [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      wire miso_w;
      pullup (miso_w);
      spi_fpga_slave #(
         .PACK_LENGTH  (8),
         .CPOL         (g >= 2),
         .CPHA         (g % 2 == 1),
         .IDLE_PATTERN (8'hFF),
         .SYNC_STAGES  (2)
      ) u_dut (
         .IN_CLOCK         (clk),
         .IN_RESET_N       (rst_n[g]),
         .SCLK             (sclk[g]),
         .CS               (cs[g]),
         .MOSI             (mosi[g]),
         .MISO             (miso_w),
         .IN_DATA          (in_data[g]),
         .IN_DATA_VALID    (in_valid[g]),
         .OUT_DATA_READY   (ready[g]),
         .OUT_RECEIVE_DATA (rxd[g]),
         .OUT_ACTION_DONE  (done[g]),
         .OUT_UNDERRUN     (underrun[g]),
         .OUT_FRAME_ERROR  (ferr[g]),
         .OUT_BUSY         (busy[g])
      );
      assign miso[g] = miso_w;
   end

   int done_cnt[4] = '{default: 0};
   int ur_cnt[4]   = '{default: 0};
   int fe_cnt[4]   = '{default: 0};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (done[i])     done_cnt[i]++;
         if (underrun[i]) ur_cnt[i]++;
         if (ferr[i])     fe_cnt[i]++;
      end
   end

   // reference model state
   logic       hold_full_m[4] = '{default: 1'b0};
   logic [7:0] hold_m[4]      = '{default: 8'h00};
   logic [7:0] rx_m[4]        = '{default: 8'h00};
   logic [7:0] cur_word[4]    = '{default: 8'h00};
   int         done_exp[4]    = '{default: 0};
   int         ur_exp[4]      = '{default: 0};
   int         fe_exp[4]      = '{default: 0};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_load(input int m);
      if (hold_full_m[m]) begin
         cur_word[m]    = hold_m[m];
         hold_full_m[m] = 1'b0;
      end else begin
         cur_word[m] = 8'hFF;
         ur_exp[m]++;
      end
   endtask

   task automatic write_word(input int m, input logic [7:0] d);
      @(negedge clk);
      in_data[m]  = d;
      in_valid[m] = 1'b1;
      @(negedge clk);
      in_valid[m] = 1'b0;
      if (!hold_full_m[m]) begin
         hold_m[m]      = d;
         hold_full_m[m] = 1'b1;
      end
   endtask

   task automatic cs_low(input int m);
      cs[m] = 1'b0;
      if (m % 2 == 0) model_load(m);
      #80;
      check("busy_low", busy[m], 1);
   endtask

   task automatic cs_high(input int m, input int nbits);
      #(HALF);
      cs[m] = 1'b1;
      repeat (12) @(negedge clk);
      if (nbits % 8 != 0) fe_exp[m]++;
   endtask

   task automatic xfer(input int m, input int nbits, input logic [31:0] tx,
                       output logic [31:0] got, output logic [31:0] exp);
      logic       cpol;
      logic       cpha;
      logic       b;
      logic [7:0] byte_in;
      cpol    = (m >= 2);
      cpha    = (m % 2 == 1);
      got     = '0;
      exp     = '0;
      byte_in = '0;
      for (int i = 0; i < nbits; i++) begin
         b = tx[nbits-1-i];
         if (cpha && (i % 8 == 0)) model_load(m);
         exp = {exp[30:0], cur_word[m][7 - (i % 8)]};
         if (!cpha) begin
            mosi[m] = b;
            #(HALF);
            got = {got[30:0], miso[m]};
            sclk[m] = ~cpol;
            #(HALF);
            sclk[m] = cpol;
         end else begin
            sclk[m] = ~cpol;
            mosi[m] = b;
            #(HALF);
            got = {got[30:0], miso[m]};
            sclk[m] = cpol;
            #(HALF);
         end
         byte_in = {byte_in[6:0], b};
         if (i % 8 == 7) begin
            rx_m[m] = byte_in;
            done_exp[m]++;
            if (!cpha) model_load(m);
         end
      end
   endtask

   task automatic frame_checks(input int m, input logic [31:0] got, input logic [31:0] exp);
      check("miso_word", got, exp);
      check("rx_data", rxd[m], rx_m[m]);
      check("done_cnt", done_cnt[m], done_exp[m]);
      check("underrun_cnt", ur_cnt[m], ur_exp[m]);
      check("frame_err_cnt", fe_cnt[m], fe_exp[m]);
      check("miso_z", miso[m], 1);
      check("busy_idle", busy[m], 0);
   endtask

   task automatic run_frame(input int m, input int nbits, input logic [31:0] tx);
      logic [31:0] got;
      logic [31:0] exp;
      cs_low(m);
      xfer(m, nbits, tx, got, exp);
      cs_high(m, nbits);
      frame_checks(m, got, exp);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] exp;
      int          m;
      int          nb;
      int          nbits;

      #1 rst_n = '0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("rst_miso_z", miso[i], 1);
         check("rst_ready", ready[i], 1);
         check("rst_rx", rxd[i], 0);
         check("rst_busy", busy[i], 0);
         check("rst_pulses", {done[i], underrun[i], ferr[i]}, 0);
      end
      rst_n = '1;
      repeat (4) @(negedge clk);

      // mode 0 single word
      write_word(0, 8'h3C);
      check("ready_full", ready[0], 0);
      run_frame(0, 8, 32'hA5);

      // modes 1..3
      for (int i = 1; i < 4; i++) begin
         write_word(i, 8'h7E);
         run_frame(i, 8, 32'h81);
      end

      // back-to-back words under one CS, second word written on READY
      write_word(0, 8'h55);
      cs_low(0);
      for (int k = 0; k < 50 && ready[0] !== 1'b1; k++) @(negedge clk);
      check("ready_wait", ready[0], 1);
      write_word(0, 8'hAA);
      xfer(0, 16, 32'h1122, got, exp);
      cs_high(0, 16);
      frame_checks(0, got, exp);

      // empty holding register -> idle pattern and one underrun
      run_frame(1, 8, 32'h00);

      // CS raised mid-word, then a clean word
      write_word(2, 8'h99);
      run_frame(2, 5, 32'h1F);
      run_frame(2, 8, 32'h5A);

      // reset mid-frame
      write_word(0, 8'h12);
      cs_low(0);
      write_word(0, 8'h34);
      check("ready_before_rst", ready[0], 0);
      xfer(0, 3, 32'h5, got, exp);
      rst_n[0] = 1'b0;
      #1;
      check("rst_mid_miso_z", miso[0], 1);
      check("rst_mid_ready", ready[0], 1);
      check("rst_mid_rx", rxd[0], 0);
      hold_full_m[0] = 1'b0;
      rx_m[0]        = 8'h00;
      cs[0]          = 1'b1;
      sclk[0]        = 1'b0;
      repeat (4) @(negedge clk);
      rst_n[0] = 1'b1;
      repeat (4) @(negedge clk);
      write_word(0, 8'h96);
      run_frame(0, 8, 32'hC3);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         m  = $urandom_range(0, 3);
         nb = $urandom_range(1, 3);
         nbits = 8 * nb;
         if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, 7);
         if ($urandom_range(0, 1) == 1) write_word(m, 8'($urandom));
         if ($urandom_range(0, 3) == 0) write_word(m, 8'($urandom));
         run_frame(m, nbits, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
